// File: rtl/debug_uart_tx_pkg.sv
// Shared definitions for the debug-unit UART link (receiver and transmitter).
package debug_defs;

  // Host protocol opcodes.
  localparam logic [7:0] OP_SIGNAL  = 8'h01;
  localparam logic [7:0] OP_OK      = 8'h02;
  localparam logic [7:0] OP_PING    = 8'h10;
  localparam logic [7:0] OP_PAUSE   = 8'h11;
  localparam logic [7:0] OP_RESUME  = 8'h12;
  localparam logic [7:0] OP_NEXT    = 8'h13;
  localparam logic [7:0] OP_PROGRAM = 8'h14;
  localparam logic [7:0] OP_NONE    = 8'hff;

  // 100 MHz system clock at 115200 baud.
  localparam int unsigned DEFAULT_CLK_PER_BIT = 868;

  // Byte-level FSM encodings, kept as fixed constants for the legacy decoders.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } byte_state_e;

endpackage

// File: rtl/debug_uart_tx_if.sv
// Request/status bundle between the debug unit core and its UART transmitter.
interface debug_uart_tx_if #(
  parameter int unsigned SIG_BYTES = 4
);
  logic                   send_ok;
  logic                   send_signal;
  logic [31:0]            pc;
  logic [8*SIG_BYTES-1:0] signals;
  logic                   busy;
  logic                   done;

  modport master (
    output send_ok, send_signal, pc, signals,
    input  busy, done
  );

  modport slave (
    input  send_ok, send_signal, pc, signals,
    output busy, done
  );
endinterface

// File: rtl/debug_uart_tx_byte.sv
// Single 8N1 frame serializer; accepts the next byte on the last stop-bit cycle
// so packet bytes run back to back.
module uart_byte_tx
  import debug_defs::*;
#(
  parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

  byte_state_e   state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud == BAUD_LAST);
  assign ready   = (state == S_IDLE) || ((state == S_STOP) && bit_end);

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          baud <= '0;
          if (valid) begin
            shreg <= data;
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= S_DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (valid) begin
              shreg <= data;
              tx    <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug-unit response transmitter: frames OP_OK and OP_SIGNAL packets onto uart_tx.
module debug_uart_tx
  import debug_defs::*;
#(
  parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int unsigned SIG_BYTES   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  debug_uart_tx_if.slave  ifc,
  output logic            uart_tx
);

  localparam int unsigned NSNAP = 4 + SIG_BYTES;
  localparam int unsigned IW    = $clog2(5 + SIG_BYTES);
  localparam int unsigned SW    = $clog2(NSNAP);
  localparam logic [IW-1:0] LAST_SIG = IW'(NSNAP);

  logic                     busy;
  logic                     done;
  logic                     pkt_sig;
  logic                     ok_pending;
  logic [IW-1:0]            byte_idx;
  logic [IW-1:0]            last_idx;
  logic [SW-1:0]            snap_sel;
  logic [NSNAP-1:0][7:0]    snap;
  logic                     byte_valid;
  logic                     byte_ready;
  logic [7:0]               byte_data;
  logic                     want_ok;

  assign ifc.busy = busy;
  assign ifc.done = done;

  assign last_idx = pkt_sig ? LAST_SIG : '0;
  assign want_ok  = ok_pending | ifc.send_ok;
  // Byte k of a SIGNAL packet (k>=1) lives at snap[k-1]; while byte_idx is
  // being sent the next one is snap[byte_idx].
  assign snap_sel = byte_idx[SW-1:0];

  // Choose the byte handed to the serializer: packet start from idle, or the
  // follow-on byte on the last stop-bit cycle of the current one.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = OP_OK;
    if (!busy) begin
      if (ifc.send_signal) begin
        byte_valid = 1'b1;
        byte_data  = OP_SIGNAL;
      end else if (ifc.send_ok) begin
        byte_valid = 1'b1;
        byte_data  = OP_OK;
      end
    end else if (byte_ready) begin
      if (byte_idx != last_idx) begin
        byte_valid = 1'b1;
        byte_data  = snap[snap_sel];
      end else if (want_ok) begin
        byte_valid = 1'b1;
        byte_data  = OP_OK;
      end
    end
  end

  // Packet sequencing, snapshot capture, pending-OK bookkeeping and done/busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pkt_sig    <= 1'b0;
      ok_pending <= 1'b0;
      byte_idx   <= '0;
      snap       <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (ifc.send_signal || ifc.send_ok) begin
          busy       <= 1'b1;
          byte_idx   <= '0;
          pkt_sig    <= ifc.send_signal;
          ok_pending <= ifc.send_signal & ifc.send_ok;
          if (ifc.send_signal) begin
            snap <= {ifc.signals, ifc.pc};
          end
        end
      end else begin
        if (ifc.send_ok) begin
          ok_pending <= 1'b1;
        end
        if (byte_ready) begin
          if (byte_idx != last_idx) begin
            byte_idx <= byte_idx + IW'(1);
          end else begin
            done <= 1'b1;
            // A pending OK (including one arriving this very cycle) chains
            // straight on; the later assignment overrides the set above.
            if (want_ok) begin
              pkt_sig    <= 1'b0;
              byte_idx   <= '0;
              ok_pending <= 1'b0;
            end else begin
              busy <= 1'b0;
            end
          end
        end
      end
    end
  end

  uart_byte_tx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_byte_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (byte_data),
    .valid (byte_valid),
    .ready (byte_ready),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx with CLK_PER_BIT=4, SIG_BYTES=4.
module tb_debug_uart_tx;

  logic clk;
  logic rst_n;
  logic uart_tx;

  debug_uart_tx_if #(.SIG_BYTES(4)) bus ();

  debug_uart_tx #(
    .CLK_PER_BIT(4),
    .SIG_BYTES  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ifc     (bus),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        send_ok;
    logic        send_signal;
    logic        inject;
    logic [31:0] pc;
    logic [31:0] sig;
    int unsigned nbytes;
    int unsigned pkt1;
    logic [79:0] exp;
  } vec_t;

  vec_t vecs [5];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, then follow the line cycle by cycle from the first
  // start-bit cycle, decoding bytes and checking timing, busy and done.
  task automatic run_packet(input vec_t v, input string tag);
    int unsigned total;
    logic [79:0] got;
    logic        cur;
    int unsigned glitches, frame_err, busy_drop, done_cnt, done_at, noisy;
    total = v.nbytes * 40;
    got = '0;
    cur = 1'b1;
    glitches = 0; frame_err = 0; busy_drop = 0; done_cnt = 0; done_at = 0; noisy = 0;
    @(negedge clk);
    bus.pc          = v.pc;
    bus.signals     = v.sig;
    bus.send_ok     = v.send_ok;
    bus.send_signal = v.send_signal;
    @(negedge clk);
    bus.send_ok     = 1'b0;
    bus.send_signal = 1'b0;
    bus.pc          = ~v.pc;
    bus.signals     = ~v.sig;
    for (int cyc = 0; cyc < int'(total); cyc++) begin
      int byte_i;
      int bit_i;
      int c;
      byte_i = cyc / 40;
      bit_i  = (cyc % 40) / 4;
      c      = cyc % 4;
      if (c == 0) begin
        cur = uart_tx;
        if (bit_i == 0) begin
          if (cur !== 1'b0) frame_err++;
        end else if (bit_i == 9) begin
          if (cur !== 1'b1) frame_err++;
        end else begin
          got[byte_i*8 + bit_i - 1] = cur;
        end
      end else if (uart_tx !== cur) begin
        glitches++;
      end
      if (bus.busy !== 1'b1) busy_drop++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      bus.send_ok     = v.inject && (cyc == 50 || cyc == 100 || cyc == 150);
      bus.send_signal = v.inject && (cyc == 200);
      @(negedge clk);
    end
    bus.send_ok     = 1'b0;
    bus.send_signal = 1'b0;
    for (int k = 0; k < int'(v.nbytes); k++)
      chk($sformatf("%s byte%0d", tag, k), 32'(got[k*8 +: 8]), 32'(v.exp[k*8 +: 8]));
    chk($sformatf("%s bit_stability", tag), glitches, 0);
    chk($sformatf("%s start_stop", tag), frame_err, 0);
    chk($sformatf("%s busy_held", tag), busy_drop, 0);
    chk($sformatf("%s mid_done_count", tag), done_cnt, (v.nbytes > v.pkt1) ? 1 : 0);
    if (v.nbytes > v.pkt1)
      chk($sformatf("%s mid_done_cycle", tag), done_at, v.pkt1 * 40);
    chk($sformatf("%s end_done", tag), 32'(bus.done), 1);
    chk($sformatf("%s end_busy", tag), 32'(bus.busy), 0);
    chk($sformatf("%s end_line", tag), 32'(uart_tx), 1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) noisy++;
    end
    chk($sformatf("%s idle_after", tag), noisy, 0);
  endtask

  initial begin
    int unsigned bad_idle;
    rst_n           = 1'b0;
    bus.send_ok     = 1'b0;
    bus.send_signal = 1'b0;
    bus.pc          = '0;
    bus.signals     = '0;

    vecs[0] = '{send_ok: 1'b1, send_signal: 1'b0, inject: 1'b0, pc: 32'h0, sig: 32'h0,
                nbytes: 1, pkt1: 1, exp: {72'h0, 8'h02}};
    vecs[1] = '{send_ok: 1'b0, send_signal: 1'b1, inject: 1'b0, pc: 32'h00400018, sig: 32'hA5C30F81,
                nbytes: 9, pkt1: 9,
                exp: {8'h00, 8'hA5, 8'hC3, 8'h0F, 8'h81, 8'h00, 8'h40, 8'h00, 8'h18, 8'h01}};
    vecs[2] = '{send_ok: 1'b1, send_signal: 1'b1, inject: 1'b0, pc: 32'h12345678, sig: 32'hDEADBEEF,
                nbytes: 10, pkt1: 9,
                exp: {8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01}};
    vecs[3] = '{send_ok: 1'b0, send_signal: 1'b1, inject: 1'b0, pc: 32'hFFFFFFFF, sig: 32'h00000000,
                nbytes: 9, pkt1: 9,
                exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01}};
    vecs[4] = '{send_ok: 1'b0, send_signal: 1'b1, inject: 1'b1, pc: 32'hCAFEF00D, sig: 32'h01020304,
                nbytes: 10, pkt1: 9,
                exp: {8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h01}};

    // Reset sanity
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(uart_tx), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst_n = 1'b1;
    bad_idle = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad_idle++;
    end
    chk("post_reset_idle", bad_idle, 0);

    for (int i = 0; i < 5; i++)
      run_packet(vecs[i], $sformatf("vec%0d", i));

    // Reset during the data bits of byte 2 of a SIGNAL packet
    @(negedge clk);
    bus.pc          = 32'h0;
    bus.signals     = 32'h0;
    bus.send_signal = 1'b1;
    @(negedge clk);
    bus.send_signal = 1'b0;
    repeat (91) @(negedge clk);
    chk("midframe_line_low", 32'(uart_tx), 0);
    chk("midframe_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_line", 32'(uart_tx), 1);
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_rst_line", 32'(uart_tx), 1);
    run_packet(vecs[0], "ok_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
